two_output_demux_buffer: RTL and testbench
==========================================

# two_output_demux_buffer

Buffered 1-to-2 demultiplexer for 16-bit datapath values: the write-side counterpart of the two-input select mux. One producer presents a value plus a select bit; the block steers it into a per-destination FIFO and delivers it to destination A or B over independent valid/ready handshakes. It sits between the ALU/result stage and two consumers (register-file write port and memory/IO write port), so that a stalled consumer does not corrupt or reorder the other path.

## Interface
- WIDTH, 16, data width of every data port
- DEPTH, 2, entries per destination FIFO; power of two, 2..8
- clk  input  1  rising-edge clock, sole clock domain
- reset  input  1  synchronous, active-high reset
- in_valid  input  1  producer has a value this cycle
- in_ready  output  1  block accepts the value this cycle
- in_sel  input  1  1 = route to A, 0 = route to B (same polarity as the mux enable)
- in_data  input  WIDTH  value to route
- outA_valid  output  1  A FIFO head is valid
- outA_ready  input  1  destination A takes the head
- outA_data  output  WIDTH  A FIFO head
- outB_valid / outB_ready / outB_data  same as A, for destination B
- countA, countB  output  8  transfers delivered on A/B, wrap modulo 256

## Operation
- Accept: push occurs when in_valid && in_ready; written to FIFO chosen by in_sel.
- in_ready = NOT full(FIFO selected by in_sel); combinational from in_sel and occupancy only, never from outX_ready (no full-FIFO pass-through).
- in_sel, in_data only sampled when in_valid; in_ready may toggle with in_sel while in_valid is high.
- Pop on X: outX_valid && outX_ready; advances read pointer, increments countX.
- outX_valid = occupancy(X) != 0; outX_data = entry at read pointer; data is don't-care while valid low (but 0 after reset).
- Per-FIFO order preserved strictly; no ordering relationship between A and B.
- Occupancy per FIFO: push only +1, pop only −1, push and pop same cycle unchanged (allowed when full only as pop — push is blocked when full; allowed when empty only as push).
- Pointers are log2(DEPTH) bits and wrap; full/empty derived from a separate occupancy counter of log2(DEPTH)+1 bits.
- countX: 8-bit, 255 + 1 → 0, no saturation.
- Unselected FIFO is unaffected by any push.
- Outputs held stable while outX_valid && !outX_ready.

## Timing
- Reset (sync, sampled on clk edge): both FIFOs empty, pointers 0, storage 0, outA_valid = outB_valid = 0, outA_data = outB_data = 0, countA = countB = 0; in_ready = 1 during the cycle after reset deasserts.
- Reset while holding data: all contents discarded; no pops reported; counts zeroed.
- Latency: value pushed at edge N is visible on outX_valid/outX_data after edge N (cycle N+1); earliest pop at edge N+1.
- Throughput: one push and one pop per FIFO per cycle; sustained 1 value/cycle per destination if consumer always ready.
- Reset asserted with in_valid high: no push that cycle.

## Test plan
- Reset then push 0x1234 sel=1: cycle after push outA_valid=1, outA_data=0x1234, outB_valid=0; pop with outA_ready=1 -> countA=1, outA_valid=0.
- Fill B: outB_ready=0, push 0x0001, 0x0002 sel=0 -> in_ready=0 for sel=0 while in_ready=1 for sel=1; push 0xAAAA sel=1 accepted; drain B -> 0x0001 then 0x0002 in order.
- Full B, same cycle outB_ready=1 and in_valid sel=0: push rejected (in_ready=0), pop occurs; next cycle in_ready=1, occupancy B=1.
- Streaming: outA_ready=1 always, push 0x0100..0x010F sel=1 back-to-back -> in_ready never drops, 16 values out in order, countA=16.
- Wrap: 256 transfers on B -> countB=0, countA unchanged; 300 transfers -> countB=44.
- Reset mid-operation with A holding 2 entries and B holding 1 -> next cycle all valids 0, data 0, counts 0, in_ready=1.

Source files
------------

// File: rtl/two_output_demux_buffer_if.sv
// Handshake bundle for the buffered 1-to-2 demultiplexer: one producer
// channel (value + select) and two independent consumer channels.
interface two_output_demux_buffer_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic             in_sel;
    logic [WIDTH-1:0] in_data;
    logic             out_a_valid;
    logic             out_a_ready;
    logic [WIDTH-1:0] out_a_data;
    logic             out_b_valid;
    logic             out_b_ready;
    logic [WIDTH-1:0] out_b_data;

    // Producer / consumers side
    modport master (
        output in_valid, in_sel, in_data, out_a_ready, out_b_ready,
        input  in_ready, out_a_valid, out_a_data, out_b_valid, out_b_data
    );

    // Demux block side
    modport slave (
        input  in_valid, in_sel, in_data, out_a_ready, out_b_ready,
        output in_ready, out_a_valid, out_a_data, out_b_valid, out_b_data
    );
endinterface

// File: rtl/two_output_demux_buffer.sv
// Buffered 1-to-2 demultiplexer. A producer value is steered by in_sel into
// one of two small FIFOs (index 0 = destination A, index 1 = destination B),
// each draining over its own valid/ready handshake so one stalled consumer
// never blocks or reorders the other. Per-destination 8-bit delivery
// counters wrap modulo 256.
module two_output_demux_buffer #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 2
) (
    input  logic                          clk_i,
    input  logic                          reset_i,
    two_output_demux_buffer_if.slave      bus,
    output logic [7:0]                    count_a_o,
    output logic [7:0]                    count_b_o
);

    localparam int              AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0]     FULL_LVL = (AW + 1)'(DEPTH);
    localparam logic [AW:0]     OCC_ONE  = (AW + 1)'(1);
    localparam logic [AW-1:0]   PTR_ONE  = AW'(1);

    logic [WIDTH-1:0] mem_q  [2][DEPTH];
    logic [AW-1:0]    wptr_q [2];
    logic [AW-1:0]    wptr_d [2];
    logic [AW-1:0]    rptr_q [2];
    logic [AW-1:0]    rptr_d [2];
    logic [AW:0]      occ_q  [2];
    logic [AW:0]      occ_d  [2];
    logic [7:0]       cnt_q  [2];
    logic [7:0]       cnt_d  [2];
    logic             full_s [2];
    logic             push_s [2];
    logic             pop_s  [2];
    logic             in_ready_s;

    // Handshake decode: readiness depends only on the selected FIFO's
    // occupancy, never on the consumer ready, so a full FIFO is never bypassed.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            full_s[i] = (occ_q[i] == FULL_LVL);
        end
        pop_s[0]   = (occ_q[0] != '0) && bus.out_a_ready;
        pop_s[1]   = (occ_q[1] != '0) && bus.out_b_ready;
        if (bus.in_sel) begin
            in_ready_s = !full_s[0];
        end else begin
            in_ready_s = !full_s[1];
        end
        push_s[0]  = bus.in_valid && in_ready_s && bus.in_sel;
        push_s[1]  = bus.in_valid && in_ready_s && !bus.in_sel;
    end

    // Next-state for pointers, occupancy and delivery counters of both FIFOs.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            wptr_d[i] = push_s[i] ? (wptr_q[i] + PTR_ONE) : wptr_q[i];
            rptr_d[i] = pop_s[i]  ? (rptr_q[i] + PTR_ONE) : rptr_q[i];
            cnt_d[i]  = pop_s[i]  ? (cnt_q[i] + 8'd1)     : cnt_q[i];
            case ({push_s[i], pop_s[i]})
                2'b10:   occ_d[i] = occ_q[i] + OCC_ONE;
                2'b01:   occ_d[i] = occ_q[i] - OCC_ONE;
                default: occ_d[i] = occ_q[i];
            endcase
        end
    end

    // State registers and storage; reset discards contents and clears data.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            for (int i = 0; i < 2; i++) begin
                for (int j = 0; j < DEPTH; j++) begin
                    mem_q[i][j] <= '0;
                end
                wptr_q[i] <= '0;
                rptr_q[i] <= '0;
                occ_q[i]  <= '0;
                cnt_q[i]  <= 8'd0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (push_s[i]) begin
                    mem_q[i][wptr_q[i]] <= bus.in_data;
                end
                wptr_q[i] <= wptr_d[i];
                rptr_q[i] <= rptr_d[i];
                occ_q[i]  <= occ_d[i];
                cnt_q[i]  <= cnt_d[i];
            end
        end
    end

    assign bus.in_ready    = in_ready_s;
    assign bus.out_a_valid = (occ_q[0] != '0);
    assign bus.out_a_data  = mem_q[0][rptr_q[0]];
    assign bus.out_b_valid = (occ_q[1] != '0);
    assign bus.out_b_data  = mem_q[1][rptr_q[1]];
    assign count_a_o       = cnt_q[0];
    assign count_b_o       = cnt_q[1];

endmodule

// File: tb/tb_two_output_demux_buffer.sv
// Self-checking bench for two_output_demux_buffer: directed scenarios plus
// randomized traffic compared against a queue-based reference model.
module tb_two_output_demux_buffer;

    localparam int DEPTH = 2;

    logic       clk;
    logic       rst;
    logic [7:0] count_a;
    logic [7:0] count_b;
    int         n_checks;
    int         n_fail;

    logic [15:0] qa[$];
    logic [15:0] qb[$];
    logic [7:0]  m_cnt_a;
    logic [7:0]  m_cnt_b;

    two_output_demux_buffer_if #(.WIDTH(16)) bus ();

    two_output_demux_buffer #(.WIDTH(16), .DEPTH(DEPTH)) dut (
        .clk_i     (clk),
        .reset_i   (rst),
        .bus       (bus),
        .count_a_o (count_a),
        .count_b_o (count_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock edge, updating the reference model from the inputs
    // present before the edge; returns 1 time unit after the edge.
    task automatic tick();
        bit rdy, pa, pb, oa, ob;
        if (rst) begin
            qa.delete();
            qb.delete();
            m_cnt_a = 8'd0;
            m_cnt_b = 8'd0;
        end else begin
            rdy = bus.in_sel ? (qa.size() < DEPTH) : (qb.size() < DEPTH);
            pa  = bus.in_valid && rdy && bus.in_sel;
            pb  = bus.in_valid && rdy && !bus.in_sel;
            oa  = (qa.size() > 0) && bus.out_a_ready;
            ob  = (qb.size() > 0) && bus.out_b_ready;
            if (oa) begin void'(qa.pop_front()); m_cnt_a = m_cnt_a + 8'd1; end
            if (ob) begin void'(qb.pop_front()); m_cnt_b = m_cnt_b + 8'd1; end
            if (pa) qa.push_back(bus.in_data);
            if (pb) qb.push_back(bus.in_data);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; bus.in_valid = 1'b1; bus.in_sel = 1'b1; bus.in_data = 16'hDEAD;
        bus.out_a_ready = 1'b0; bus.out_b_ready = 1'b0;
        tick(); tick();
        rst = 1'b0; bus.in_valid = 1'b0; #1;
        n_checks++; if (bus.out_a_valid !== 1'b0) begin n_fail++; $display("FAIL rst_a_valid got %b exp 0", bus.out_a_valid); end
        n_checks++; if (bus.out_b_valid !== 1'b0) begin n_fail++; $display("FAIL rst_b_valid got %b exp 0", bus.out_b_valid); end
        n_checks++; if (bus.out_a_data !== 16'h0000) begin n_fail++; $display("FAIL rst_a_data got %h exp 0000", bus.out_a_data); end
        n_checks++; if (bus.out_b_data !== 16'h0000) begin n_fail++; $display("FAIL rst_b_data got %h exp 0000", bus.out_b_data); end
        n_checks++; if (count_a !== 8'd0 || count_b !== 8'd0) begin n_fail++; $display("FAIL rst_counts got %0d/%0d exp 0/0", count_a, count_b); end
        n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_in_ready_sel1 got %b exp 1", bus.in_ready); end
        bus.in_sel = 1'b0; #1;
        n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_in_ready_sel0 got %b exp 1", bus.in_ready); end
    endtask

    task automatic test_basic_a();
        bus.in_valid = 1'b1; bus.in_sel = 1'b1; bus.in_data = 16'h1234;
        tick();
        bus.in_valid = 1'b0;
        n_checks++; if (bus.out_a_valid !== 1'b1) begin n_fail++; $display("FAIL basic_a_valid got %b exp 1", bus.out_a_valid); end
        n_checks++; if (bus.out_a_data !== 16'h1234) begin n_fail++; $display("FAIL basic_a_data got %h exp 1234", bus.out_a_data); end
        n_checks++; if (bus.out_b_valid !== 1'b0) begin n_fail++; $display("FAIL basic_b_valid got %b exp 0", bus.out_b_valid); end
        bus.out_a_ready = 1'b1;
        tick();
        bus.out_a_ready = 1'b0;
        n_checks++; if (count_a !== 8'd1) begin n_fail++; $display("FAIL basic_count_a got %0d exp 1", count_a); end
        n_checks++; if (bus.out_a_valid !== 1'b0) begin n_fail++; $display("FAIL basic_a_empty got %b exp 0", bus.out_a_valid); end
    endtask

    task automatic test_fill_b();
        bus.in_valid = 1'b1; bus.in_sel = 1'b0; bus.in_data = 16'h0001; tick();
        bus.in_data = 16'h0002; tick();
        #1;
        n_checks++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL fill_ready_sel0 got %b exp 0", bus.in_ready); end
        bus.in_sel = 1'b1; bus.in_data = 16'hAAAA; #1;
        n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL fill_ready_sel1 got %b exp 1", bus.in_ready); end
        tick();
        bus.in_valid = 1'b0;
        n_checks++; if (bus.out_a_data !== 16'hAAAA || bus.out_a_valid !== 1'b1) begin n_fail++; $display("FAIL fill_a_head got %h/%b exp aaaa/1", bus.out_a_data, bus.out_a_valid); end
        n_checks++; if (bus.out_b_data !== 16'h0001) begin n_fail++; $display("FAIL fill_b_first got %h exp 0001", bus.out_b_data); end
        bus.out_b_ready = 1'b1; tick();
        n_checks++; if (bus.out_b_data !== 16'h0002 || bus.out_b_valid !== 1'b1) begin n_fail++; $display("FAIL fill_b_second got %h/%b exp 0002/1", bus.out_b_data, bus.out_b_valid); end
        tick();
        n_checks++; if (bus.out_b_valid !== 1'b0) begin n_fail++; $display("FAIL fill_b_drained got %b exp 0", bus.out_b_valid); end
        bus.out_b_ready = 1'b0; bus.out_a_ready = 1'b1; tick();
        bus.out_a_ready = 1'b0;
    endtask

    task automatic test_full_pushpop();
        bus.in_valid = 1'b1; bus.in_sel = 1'b0; bus.in_data = 16'h0011; tick();
        bus.in_data = 16'h0022; tick();
        bus.in_data = 16'h0033; bus.out_b_ready = 1'b1; #1;
        n_checks++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL fullpp_ready got %b exp 0", bus.in_ready); end
        tick();
        bus.in_valid = 1'b0; bus.out_b_ready = 1'b0; #1;
        n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL fullpp_ready_after got %b exp 1", bus.in_ready); end
        n_checks++; if (bus.out_b_data !== 16'h0022 || bus.out_b_valid !== 1'b1) begin n_fail++; $display("FAIL fullpp_head got %h/%b exp 0022/1", bus.out_b_data, bus.out_b_valid); end
        bus.in_valid = 1'b1; bus.in_data = 16'h0044; tick();
        bus.in_valid = 1'b0; #1;
        n_checks++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL fullpp_occ1 got ready %b exp 0", bus.in_ready); end
        bus.out_b_ready = 1'b1; tick(); tick();
        bus.out_b_ready = 1'b0;
        n_checks++; if (bus.out_b_valid !== 1'b0) begin n_fail++; $display("FAIL fullpp_drain got %b exp 0", bus.out_b_valid); end
        n_checks++; if (count_b !== 8'd5) begin n_fail++; $display("FAIL fullpp_count_b got %0d exp 5", count_b); end
    endtask

    task automatic test_streaming();
        logic [7:0] start;
        start = m_cnt_a;
        bus.out_a_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            bus.in_valid = 1'b1; bus.in_sel = 1'b1; bus.in_data = 16'h0100 + 16'(i); #1;
            n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL stream_ready[%0d] got %b exp 1", i, bus.in_ready); end
            tick();
            n_checks++; if (bus.out_a_valid !== 1'b1 || bus.out_a_data !== 16'h0100 + 16'(i)) begin
                n_fail++; $display("FAIL stream_data[%0d] got %h/%b exp %h/1", i, bus.out_a_data, bus.out_a_valid, 16'h0100 + 16'(i)); end
        end
        bus.in_valid = 1'b0; tick();
        bus.out_a_ready = 1'b0;
        n_checks++; if (bus.out_a_valid !== 1'b0) begin n_fail++; $display("FAIL stream_empty got %b exp 0", bus.out_a_valid); end
        n_checks++; if (count_a !== start + 8'd16) begin n_fail++; $display("FAIL stream_count_a got %0d exp %0d", count_a, start + 8'd16); end
    endtask

    task automatic test_wrap();
        rst = 1'b1; bus.in_valid = 1'b0; tick();
        rst = 1'b0; bus.out_b_ready = 1'b1; bus.out_a_ready = 1'b0; bus.in_sel = 1'b0;
        for (int i = 0; i < 300; i++) begin
            bus.in_valid = 1'b1; bus.in_data = 16'($urandom);
            tick();
            n_checks++; if (bus.out_b_data !== qb[0]) begin n_fail++; $display("FAIL wrap_data[%0d] got %h exp %h", i, bus.out_b_data, qb[0]); end
            if (i == 255) begin
                bus.in_valid = 1'b0; tick();
                n_checks++; if (count_b !== 8'd0 || count_a !== 8'd0) begin n_fail++; $display("FAIL wrap_256 got %0d/%0d exp 0/0", count_a, count_b); end
            end
        end
        bus.in_valid = 1'b0; tick();
        bus.out_b_ready = 1'b0;
        n_checks++; if (count_b !== 8'd44 || count_a !== 8'd0) begin n_fail++; $display("FAIL wrap_300 got %0d/%0d exp 0/44", count_a, count_b); end
    endtask

    task automatic test_reset_mid();
        bus.out_a_ready = 1'b0; bus.out_b_ready = 1'b0;
        bus.in_valid = 1'b1; bus.in_sel = 1'b1; bus.in_data = 16'h0005; tick();
        bus.in_data = 16'h0006; tick();
        bus.in_sel = 1'b0; bus.in_data = 16'h0007; tick();
        rst = 1'b1; bus.in_sel = 1'b1; bus.in_data = 16'h0008; tick();
        rst = 1'b0; bus.in_valid = 1'b0; #1;
        n_checks++; if (bus.out_a_valid !== 1'b0 || bus.out_b_valid !== 1'b0) begin n_fail++; $display("FAIL mid_valids got %b/%b exp 0/0", bus.out_a_valid, bus.out_b_valid); end
        n_checks++; if (bus.out_a_data !== 16'h0 || bus.out_b_data !== 16'h0) begin n_fail++; $display("FAIL mid_data got %h/%h exp 0/0", bus.out_a_data, bus.out_b_data); end
        n_checks++; if (count_a !== 8'd0 || count_b !== 8'd44 - 8'd44) begin n_fail++; $display("FAIL mid_counts got %0d/%0d exp 0/0", count_a, count_b); end
        n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL mid_ready_sel1 got %b exp 1", bus.in_ready); end
        bus.in_sel = 1'b0; #1;
        n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL mid_ready_sel0 got %b exp 1", bus.in_ready); end
        tick();
        n_checks++; if (bus.out_a_valid !== 1'b0) begin n_fail++; $display("FAIL mid_no_push got %b exp 0", bus.out_a_valid); end
    endtask

    task automatic test_random();
        bit exp_rdy;
        for (int c = 0; c < 600; c++) begin
            rst             = ($urandom_range(0, 79) == 0);
            bus.in_valid    = $urandom_range(0, 3) != 0;
            bus.in_sel      = 1'($urandom);
            bus.in_data     = 16'($urandom);
            bus.out_a_ready = $urandom_range(0, 2) == 0;
            bus.out_b_ready = $urandom_range(0, 2) == 0;
            #1;
            exp_rdy = bus.in_sel ? (qa.size() < DEPTH) : (qb.size() < DEPTH);
            n_checks++; if (bus.in_ready !== exp_rdy) begin n_fail++; $display("FAIL rand_ready[%0d] got %b exp %b", c, bus.in_ready, exp_rdy); end
            n_checks++; if (bus.out_a_valid !== (qa.size() != 0)) begin n_fail++; $display("FAIL rand_a_valid[%0d] got %b exp %b", c, bus.out_a_valid, qa.size() != 0); end
            n_checks++; if (bus.out_b_valid !== (qb.size() != 0)) begin n_fail++; $display("FAIL rand_b_valid[%0d] got %b exp %b", c, bus.out_b_valid, qb.size() != 0); end
            if (qa.size() != 0) begin
                n_checks++; if (bus.out_a_data !== qa[0]) begin n_fail++; $display("FAIL rand_a_data[%0d] got %h exp %h", c, bus.out_a_data, qa[0]); end
            end
            if (qb.size() != 0) begin
                n_checks++; if (bus.out_b_data !== qb[0]) begin n_fail++; $display("FAIL rand_b_data[%0d] got %h exp %h", c, bus.out_b_data, qb[0]); end
            end
            n_checks++; if (count_a !== m_cnt_a || count_b !== m_cnt_b) begin n_fail++; $display("FAIL rand_counts[%0d] got %0d/%0d exp %0d/%0d", c, count_a, count_b, m_cnt_a, m_cnt_b); end
            tick();
        end
        rst = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        m_cnt_a  = 8'd0;
        m_cnt_b  = 8'd0;
        rst = 1'b1;
        bus.in_valid = 1'b0; bus.in_sel = 1'b0; bus.in_data = 16'h0;
        bus.out_a_ready = 1'b0; bus.out_b_ready = 1'b0;
        #1;
        test_reset();
        test_basic_a();
        test_fill_b();
        test_full_pushpop();
        test_streaming();
        test_wrap();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
